// File: rtl/wavetable_voice_scheduler.sv
// Time-multiplexes one shared wavetable lookup across VOICES oscillator voices.
// Each sample_tick issues voice phases in order and returns tagged amplitudes.
module wavetable_voice_scheduler #(
  parameter int VOICES           = 8,
  parameter int VOICE_BITS       = $clog2(VOICES),
  parameter int WT_LATENCY       = 1,
  parameter int PHASE_INDEX_BITS = 16,
  parameter int AMPLITUDE_BITS   = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        sample_tick,
  input  logic                        cfg_we,
  input  logic [VOICE_BITS-1:0]       cfg_voice,
  input  logic [PHASE_INDEX_BITS-1:0] cfg_increment,
  input  logic                        cfg_enable,
  input  logic                        cfg_phase_reset,
  output logic [PHASE_INDEX_BITS-1:0] wt_phase,
  input  logic [AMPLITUDE_BITS-1:0]   wt_q,
  output logic                        out_valid,
  output logic [VOICE_BITS-1:0]       out_voice,
  output logic [AMPLITUDE_BITS-1:0]   out_amplitude,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        overrun
);

  localparam int DEPTH    = WT_LATENCY + 1;
  localparam int CNT_BITS = $clog2(WT_LATENCY + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                      state_q;
  logic [VOICE_BITS-1:0]       index_q;
  logic [CNT_BITS-1:0]         drain_q;

  logic [PHASE_INDEX_BITS-1:0] phase_q  [VOICES];
  logic [PHASE_INDEX_BITS-1:0] phase_d  [VOICES];
  logic [PHASE_INDEX_BITS-1:0] incr_q   [VOICES];
  logic                        enable_q [VOICES];

  logic                        tag_valid_q [DEPTH];
  logic [VOICE_BITS-1:0]       tag_voice_q [DEPTH];
  logic                        tag_en_q    [DEPTH];

  logic [PHASE_INDEX_BITS-1:0] wt_phase_q;
  logic                        out_valid_q;
  logic [VOICE_BITS-1:0]       out_voice_q;
  logic [AMPLITUDE_BITS-1:0]   out_amplitude_q;
  logic                        frame_done_q;
  logic                        busy_q;
  logic                        overrun_q;

  logic issue;
  logic last_voice;
  logic tick_accept;

  assign issue       = (state_q == ISSUE);
  assign last_voice  = (index_q == VOICE_BITS'(VOICES - 1));
  // busy_q stays high through the frame_done cycle, so a tick there is rejected
  assign tick_accept = sample_tick && (state_q == IDLE) && !busy_q;

  // Phase reset from the config port wins over a same-cycle advance.
  always_comb begin
    for (int unsigned v = 0; v < VOICES; v++) begin
      phase_d[v] = phase_q[v];
      if (cfg_we && cfg_phase_reset && (32'(cfg_voice) == v))
        phase_d[v] = '0;
      else if (issue && (32'(index_q) == v) && enable_q[v])
        phase_d[v] = phase_q[v] + incr_q[v];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      index_q         <= '0;
      drain_q         <= '0;
      wt_phase_q      <= '0;
      out_valid_q     <= 1'b0;
      out_voice_q     <= '0;
      out_amplitude_q <= '0;
      frame_done_q    <= 1'b0;
      busy_q          <= 1'b0;
      overrun_q       <= 1'b0;
      for (int unsigned v = 0; v < VOICES; v++) begin
        phase_q[v]  <= '0;
        incr_q[v]   <= '0;
        enable_q[v] <= 1'b0;
      end
      for (int unsigned d = 0; d < DEPTH; d++) begin
        tag_valid_q[d] <= 1'b0;
        tag_voice_q[d] <= '0;
        tag_en_q[d]    <= 1'b0;
      end
    end else begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        phase_q[v] <= phase_d[v];
        if (cfg_we && (32'(cfg_voice) == v)) begin
          incr_q[v]   <= cfg_increment;
          enable_q[v] <= cfg_enable;
        end
      end

      // Tag delay line aligned with the wavetable read latency.
      tag_valid_q[0] <= issue;
      tag_voice_q[0] <= index_q;
      tag_en_q[0]    <= enable_q[index_q];
      for (int unsigned d = 1; d < DEPTH; d++) begin
        tag_valid_q[d] <= tag_valid_q[d-1];
        tag_voice_q[d] <= tag_voice_q[d-1];
        tag_en_q[d]    <= tag_en_q[d-1];
      end

      out_valid_q  <= tag_valid_q[DEPTH-1];
      frame_done_q <= tag_valid_q[DEPTH-1] &&
                      (tag_voice_q[DEPTH-1] == VOICE_BITS'(VOICES - 1));
      if (tag_valid_q[DEPTH-1]) begin
        out_voice_q     <= tag_voice_q[DEPTH-1];
        out_amplitude_q <= tag_en_q[DEPTH-1] ? wt_q : '0;
      end

      if (sample_tick && busy_q)
        overrun_q <= 1'b1;

      if (tick_accept)
        busy_q <= 1'b1;
      else if (frame_done_q)
        busy_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (tick_accept) begin
            state_q <= ISSUE;
            index_q <= '0;
          end
        end
        ISSUE: begin
          wt_phase_q <= phase_q[index_q];
          if (last_voice) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end else begin
            index_q <= index_q + VOICE_BITS'(1);
          end
        end
        DRAIN: begin
          if (drain_q == CNT_BITS'(WT_LATENCY))
            state_q <= IDLE;
          else
            drain_q <= drain_q + CNT_BITS'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wt_phase      = wt_phase_q;
  assign out_valid     = out_valid_q;
  assign out_voice     = out_voice_q;
  assign out_amplitude = out_amplitude_q;
  assign frame_done    = frame_done_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// Bench for wavetable_voice_scheduler: frame-level schedule model plus directed
// frames with hand-computed phases, amplitudes and timing.
module tb_wavetable_voice_scheduler;

  localparam int V  = 4;
  localparam int L  = 1;
  localparam int VB = 2;
  localparam int F  = V + L + 1;

  logic        clock;
  logic        reset_n;
  logic        sample_tick;
  logic        cfg_we;
  logic [VB-1:0] cfg_voice;
  logic [15:0] cfg_increment;
  logic        cfg_enable;
  logic        cfg_phase_reset;
  logic [15:0] wt_phase;
  logic [15:0] wt_q;
  logic        out_valid;
  logic [VB-1:0] out_voice;
  logic [15:0] out_amplitude;
  logic        frame_done;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  wavetable_voice_scheduler #(
    .VOICES(V), .VOICE_BITS(VB), .WT_LATENCY(L),
    .PHASE_INDEX_BITS(16), .AMPLITUDE_BITS(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_increment(cfg_increment),
    .cfg_enable(cfg_enable), .cfg_phase_reset(cfg_phase_reset),
    .wt_phase(wt_phase), .wt_q(wt_q), .out_valid(out_valid),
    .out_voice(out_voice), .out_amplitude(out_amplitude),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] wtf(input logic [15:0] p);
    return {p[7:0], p[15:8]} ^ 16'h5A3C;
  endfunction

  // Wavetable stand-in: one registered ROM read.
  always @(posedge clock) wt_q <= wtf(wt_phase);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Schedule model: a frame accepted at edge s issues voice i at edge s+1+i,
  // whose result appears at edge s+1+i+L+1; busy covers cycles s..s+F.
  int          cyc = 0;
  bit          model_ok = 0;
  bit          in_frame = 0;
  int          start = 0;
  logic [15:0] mph [V];
  logic [15:0] minc [V];
  bit          men [V];
  bit          sv [8];
  int          svoice [8];
  logic [15:0] samp [8];
  bit          e_valid, e_fd, e_busy, e_ovr;
  int          e_voice;
  logic [15:0] e_amp, e_wtp;

  always @(posedge clock) begin
    int slot, i, ns;
    bit busy_seen;
    cyc++;
    slot = cyc % 8;
    if (!reset_n) begin
      model_ok = 1;
      in_frame = 0;
      for (int k = 0; k < V; k++) begin mph[k] = 0; minc[k] = 0; men[k] = 0; end
      for (int k = 0; k < 8; k++) sv[k] = 0;
      e_valid = 0; e_fd = 0; e_busy = 0; e_ovr = 0;
      e_voice = 0; e_amp = 0; e_wtp = 0;
    end else begin
      e_valid = sv[slot];
      e_fd    = sv[slot] && (svoice[slot] == V - 1);
      if (sv[slot]) begin e_voice = svoice[slot]; e_amp = samp[slot]; end
      sv[slot] = 0;
      busy_seen = in_frame && (cyc >= start + 1) && (cyc <= start + F + 1);
      if (sample_tick) begin
        if (busy_seen) e_ovr = 1;
        else begin in_frame = 1; start = cyc; end
      end
      if (in_frame && (cyc >= start + 1) && (cyc <= start + V)) begin
        i = cyc - start - 1;
        ns = (cyc + L + 1) % 8;
        e_wtp = mph[i];
        sv[ns] = 1;
        svoice[ns] = i;
        samp[ns] = men[i] ? wtf(mph[i]) : 16'h0;
        if (men[i]) mph[i] = mph[i] + minc[i];
      end
      if (cfg_we && (int'(cfg_voice) < V)) begin
        if (cfg_phase_reset) mph[cfg_voice] = 0;
        minc[cfg_voice] = cfg_increment;
        men[cfg_voice]  = cfg_enable;
      end
      e_busy = in_frame && (cyc >= start) && (cyc <= start + F);
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      chk("m_out_valid", 32'(out_valid), 32'(e_valid));
      chk("m_frame_done", 32'(frame_done), 32'(e_fd));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_overrun", 32'(overrun), 32'(e_ovr));
      chk("m_wt_phase", 32'(wt_phase), 32'(e_wtp));
      if (e_valid) begin
        chk("m_out_voice", 32'(out_voice), 32'(e_voice));
        chk("m_out_amplitude", 32'(out_amplitude), 32'(e_amp));
      end
    end
  end

  task automatic cfg(input int v, input logic [15:0] inc, input bit en, input bit pr);
    cfg_we = 1; cfg_voice = VB'(v); cfg_increment = inc;
    cfg_enable = en; cfg_phase_reset = pr;
    @(posedge clock); #1;
    cfg_we = 0; cfg_phase_reset = 0;
  endtask

  // Tick accepted at edge 0; checks cycles 1..7 against literal expectations.
  task automatic run_frame(input logic [15:0] p0, p1, p2, p3, a0, a1,
                           input bit t2, input bit t7, input bit pr0);
    logic [15:0] ph [V];
    ph[0] = p0; ph[1] = p1; ph[2] = p2; ph[3] = p3;
    sample_tick = 1;
    @(posedge clock); #1;
    sample_tick = 0;
    if (pr0) begin
      cfg_we = 1; cfg_voice = 0; cfg_increment = 16'h0100;
      cfg_enable = 1; cfg_phase_reset = 1;
    end
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock); #1;
      sample_tick = 0;
      cfg_we = 0; cfg_phase_reset = 0;
      if (k >= 1 && k <= 4) chk("d_wt_phase", 32'(wt_phase), 32'(ph[k-1]));
      chk("d_out_valid", 32'(out_valid), 32'((k >= 3 && k <= 6) ? 1 : 0));
      if (k >= 3 && k <= 6) chk("d_out_voice", 32'(out_voice), 32'(k - 3));
      if (k == 3) chk("d_amp_v0", 32'(out_amplitude), 32'(a0));
      if (k == 4) chk("d_amp_v1", 32'(out_amplitude), 32'(a1));
      chk("d_frame_done", 32'(frame_done), 32'((k == 6) ? 1 : 0));
      chk("d_busy", 32'(busy), 32'((k == 7) ? 0 : 1));
      if (k == 1) sample_tick = t2;
      if (k == 6) sample_tick = t7;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_voice"}, 32'(out_voice), 0);
    chk({tag, "_out_amplitude"}, 32'(out_amplitude), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_wt_phase"}, 32'(wt_phase), 0);
  endtask

  initial begin
    reset_n = 0; sample_tick = 0; cfg_we = 0; cfg_voice = 0;
    cfg_increment = 0; cfg_enable = 0; cfg_phase_reset = 0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1;
    chk_all_zero("rst");

    cfg(0, 16'h0100, 1, 0);
    cfg(1, 16'h0200, 1, 0);
    cfg(2, 16'h0300, 1, 0);
    cfg(3, 16'h0400, 1, 0);

    run_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h5A3C, 16'h5A3C, 0, 0, 0);
    run_frame(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h5A3D, 16'h5A3E, 0, 0, 0);
    run_frame(16'h0200, 16'h0400, 16'h0600, 16'h0800, 16'h5A3E, 16'h5A38, 0, 0, 0);

    // Voice 2 steered to 0xFFFF, then stepped by 1 across the wrap.
    cfg(2, 16'hF6FF, 1, 0);
    run_frame(16'h0300, 16'h0600, 16'h0900, 16'h0C00, 16'h5A3F, 16'h5A3A, 0, 0, 0);
    cfg(2, 16'h0001, 1, 0);
    run_frame(16'h0400, 16'h0800, 16'hFFFF, 16'h1000, 16'h5A38, 16'h5A34, 0, 0, 0);
    run_frame(16'h0500, 16'h0A00, 16'h0000, 16'h1400, 16'h5A39, 16'h5A36, 0, 0, 0);

    cfg(1, 16'h0200, 0, 0);
    run_frame(16'h0600, 16'h0C00, 16'h0001, 16'h1800, 16'h5A3A, 16'h0000, 0, 0, 0);
    run_frame(16'h0700, 16'h0C00, 16'h0002, 16'h1C00, 16'h5A3B, 16'h0000, 0, 0, 0);

    chk("d_overrun_before", 32'(overrun), 0);
    run_frame(16'h0800, 16'h0C00, 16'h0003, 16'h2000, 16'h5A34, 16'h0000, 1, 1, 0);
    chk("d_overrun_set", 32'(overrun), 1);
    run_frame(16'h0900, 16'h0C00, 16'h0004, 16'h2400, 16'h5A35, 16'h0000, 0, 0, 0);
    chk("d_overrun_sticky", 32'(overrun), 1);

    run_frame(16'h0A00, 16'h0C00, 16'h0005, 16'h2800, 16'h5A36, 16'h0000, 0, 0, 1);
    run_frame(16'h0000, 16'h0C00, 16'h0006, 16'h2C00, 16'h5A3C, 16'h0000, 0, 0, 0);

    // Reset in the middle of a frame: pending results must never appear.
    sample_tick = 1;
    @(posedge clock); #1;
    sample_tick = 0;
    repeat (4) begin @(posedge clock); #1; end
    reset_n = 0;
    @(posedge clock); #1;
    chk_all_zero("mid_rst");
    reset_n = 1;
    repeat (6) begin
      @(posedge clock); #1;
      chk("post_rst_out_valid", 32'(out_valid), 0);
    end
    run_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    chk("post_rst_overrun", 32'(overrun), 0);

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wavetable_voice_scheduler.md
Name: wavetable_voice_scheduler

Overview:
Time-multiplexes one shared sine_wavetable/lerp lookup across VOICES oscillator voices. On each sample_tick it walks the voices in order 0..VOICES-1, one per clock. For each voice it presents the stored phase to the wavetable, advances that phase by the voice's increment, and tags the returning amplitude with its voice number. It sits between the per-voice configuration (register interface) and the mixer, which consumes out_valid/out_voice/out_amplitude.

Parameters:
VOICES, 8, number of time-multiplexed voices (>=2, power of two not required).
VOICE_BITS, $clog2(VOICES), width of voice index.
WT_LATENCY, 1, cycles from wt_phase register update to valid wt_q (wavetable registers the ROM read; lerp is combinational).

Ports:
clock  input  1  system clock, all logic on posedge.
reset_n  input  1  synchronous active-low reset.
sample_tick  input  1  one-cycle pulse at sample rate; starts a frame.
cfg_we  input  1  write strobe for voice configuration.
cfg_voice  input  VOICE_BITS  voice addressed by the write.
cfg_increment  input  PHASE_INDEX_BITS  phase increment per sample (phase_index_type).
cfg_enable  input  1  voice enable.
cfg_phase_reset  input  1  when set with cfg_we, zero the voice's phase.
wt_phase  output  PHASE_INDEX_BITS  phase to sine_wavetable (registered).
wt_q  input  AMPLITUDE_BITS  amplitude from sine_wavetable.
out_valid  output  1  out_voice/out_amplitude valid this cycle.
out_voice  output  VOICE_BITS  voice index of out_amplitude.
out_amplitude  output  AMPLITUDE_BITS  sample for out_voice (amplitude type).
frame_done  output  1  one-cycle pulse with the last out_valid of a frame.
busy  output  1  frame in progress (IDLE not reached).
overrun  output  1  sticky: sample_tick arrived while busy.

Behaviour:
- Reset (reset_n=0 at posedge): all phases, increments and enables cleared to 0. wt_phase=0, out_valid=0, out_voice=0, out_amplitude=0, frame_done=0, busy=0, overrun=0. In-flight pipeline tags are discarded, so no out_valid is issued for a frame interrupted by reset.
- FSM states:
  - IDLE: on sample_tick go to ISSUE with index=0.
  - ISSUE: each cycle register wt_phase<=phase[index] and push tag {valid=1, voice=index, enabled=enable[index]} into the delay line. If index==VOICES-1, go to DRAIN; else index++.
  - DRAIN: hold for WT_LATENCY+1 cycles until the last tag emerges, then return to IDLE.
- Phase update happens in the same cycle as issue:
  - Enabled voice: phase[index] <= phase[index] + increment[index], modulo 2^PHASE_INDEX_BITS (natural wrap, no saturation).
  - Disabled voice: phase is held.
  - wt_phase always carries the pre-increment phase.
- Output timing:
  - A tag issued at edge k emerges at edge k+WT_LATENCY+1. The block then registers out_valid=1, out_voice=tag.voice and out_amplitude=wt_q, or out_amplitude=0 if tag.enabled=0.
  - out_valid is exactly VOICES consecutive cycles per frame, voices in ascending order.
  - frame_done=1 on the same cycle as out_voice=VOICES-1.
- busy=1 from the edge after sample_tick is accepted through the cycle of frame_done. Frame length is VOICES+WT_LATENCY+1 cycles from tick to frame_done.
- sample_tick while busy: ignored (no restart, no queueing) and overrun<=1. overrun clears only on reset.
- sample_tick coincident with frame_done: busy is still 1, so the tick is ignored and overrun is set.
- Config writes:
  - Increment and enable writes take effect at the next edge.
  - If the write targets the voice being issued in the same cycle, the phase advance uses the old increment/enable. The new values apply from the next frame.
  - cfg_phase_reset with cfg_we: phase[cfg_voice]<=0, with priority over a same-cycle advance of that voice.
  - Writes with cfg_voice>=VOICES are ignored.
- wt_phase holds its last value in IDLE and DRAIN.

Test Plan:
- Reset then single frame, VOICES=4, WT_LATENCY=1, voices 0..3 enabled, increments 0x100,0x200,0x300,0x400, tick at cycle 0 -> wt_phase=0 for voices 0..3 on cycles 1..4; out_valid cycles 3..6 with out_voice 0,1,2,3; frame_done on cycle 6; stored phases 0x100..0x400; busy low at cycle 7.
- Second tick -> wt_phase sequence 0x100,0x200,0x300,0x400; out_amplitude matches the wavetable model for those phases; third frame presents 0x200,0x400,0x600,0x800.
- Wrap: cfg increment=1 on voice 2, phase preset via repeated frames to 2^PHASE_INDEX_BITS-1 -> next frame presents max value, following frame presents 0.
- Voice 1 disabled -> out_amplitude=0 for voice 1, its phase unchanged across frames, other voices advance normally.
- Tick during busy (at cycle 2) and tick coincident with frame_done -> no extra out_valid, frame timing unchanged, overrun=1 and stays 1 until reset.
- reset_n low at cycle 4 mid-frame -> no out_valid after reset, all outputs 0. cfg write to voice 0 with cfg_phase_reset during its issue cycle -> that voice's phase reads 0 next frame.
